// File: rtl/spi_ncs_target.sv
// spi_ncs_target: SPI mode-0 target, MSB first, one FRAME_BITS word per nCs-low window.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   nRst       asynchronous active-low reset
//   nCs_i      chip select pad, active low, asynchronous to clk
//   sck_i      SPI clock pad, idles low, asynchronous to clk
//   mosi_i     serial data pad
//   miso_o     serial response data
//   miso_oe_o  MISO pad enable, high only while selected
//   tx_data    response word, captured when a frame starts
//   rx_data    last good received word, held until the next good frame
//   rx_valid   one-cycle pulse when rx_data updates
//   busy       high while a frame is in progress
//   frame_err  (SPI_TARGET_FRAME_ERR_EN only) one-cycle pulse for a frame of the wrong length
//   err_cnt    (SPI_TARGET_FRAME_ERR_EN only) saturating count of frame_err pulses
//
// Optional feature macro: SPI_TARGET_FRAME_ERR_EN.
module spi_ncs_target #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  nCs_i,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_TARGET_FRAME_ERR_EN
  ,
  output logic                  frame_err,
  output logic [7:0]            err_cnt
`endif
);
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME_BITS);
  localparam logic [CW-1:0] BIT_MAX = CW'(FRAME_BITS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] ncs_sync, sck_sync, mosi_sync;
  logic ncs_hist, sck_hist, armed, good;
  logic [FW-1:0] fill;
  logic [CW-1:0] bit_cnt;
  logic [FRAME_BITS-2:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic ncs_s, sck_s, mosi_s, ncs_fall, ncs_rise, sck_rise, sck_fall, frame_end;
  assign ncs_s = ncs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ncs_fall = ncs_hist & ~ncs_s;
  assign ncs_rise = ~ncs_hist & ncs_s;
  assign sck_rise = ~sck_hist & sck_s;
  assign sck_fall = sck_hist & ~sck_s;
  assign frame_end = (state == SHIFT) && ncs_rise;
  assign busy = (state == SHIFT);
  // The nCs chain is preset high by reset, so armed waits until the chain has
  // been refilled from the pad; a pad held low through reset then never arms.
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      ncs_sync <= '1;
      sck_sync <= '0;
      mosi_sync <= '0;
      ncs_hist <= 1'b1;
      sck_hist <= 1'b0;
      fill <= '0;
      armed <= 1'b0;
    end else begin
      ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], nCs_i};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      ncs_hist <= ncs_s;
      sck_hist <= sck_s;
      fill <= (fill == FILL_MAX) ? fill : fill + 1'b1;
      armed <= armed | ((fill == FILL_MAX) & ncs_s);
    end
  // tx_shift holds the bits still to be sent after the one currently on miso_o;
  // zeros shift in, so miso_o drops to 0 once the word is exhausted.
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      miso_o <= 1'b0;
      miso_oe_o <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      good <= 1'b0;
    end else begin
      good <= frame_end && bit_cnt == FRAME_LEN;
      rx_valid <= good;
      if (good) rx_data <= rx_shift;
      if (state == IDLE) begin
        if (ncs_fall && armed) begin
          tx_shift <= tx_data[FRAME_BITS-2:0];
          bit_cnt <= '0;
          miso_o <= tx_data[FRAME_BITS-1];
          miso_oe_o <= 1'b1;
          state <= SHIFT;
        end
      end else if (ncs_rise) begin
        miso_oe_o <= 1'b0;
        miso_o <= 1'b0;
        state <= IDLE;
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
          bit_cnt <= (bit_cnt == BIT_MAX) ? bit_cnt : bit_cnt + 1'b1;
        end
        if (sck_fall) begin
          tx_shift <= {tx_shift[FRAME_BITS-3:0], 1'b0};
          miso_o <= tx_shift[FRAME_BITS-2];
        end
      end
    end
`ifdef SPI_TARGET_FRAME_ERR_EN
  logic bad;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      bad <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      bad <= frame_end && bit_cnt != FRAME_LEN;
      frame_err <= bad;
      err_cnt <= (bad && err_cnt != 8'hff) ? err_cnt + 8'd1 : err_cnt;
    end
`endif
endmodule

// File: tb/tb_spi_ncs_target.sv
// tb_spi_ncs_target: randomized and directed frames checked against a delayed-pad frame model.
module tb_spi_ncs_target;
  localparam int FB = 24;
  localparam int SD = 2;
  logic clk = 1'b0;
  logic nRst, ncs, sck, mosi, miso_o, miso_oe_o, rx_valid, busy;
  logic [FB-1:0] tx_data, rx_data;
`ifdef SPI_TARGET_FRAME_ERR_EN
  logic frame_err;
  logic [7:0] err_cnt;
`endif
  int total = 0, bad = 0, errs = 0;
  logic [FB-1:0] pulses[$];
  always #5 clk = ~clk;
  spi_ncs_target #(.FRAME_BITS(FB), .SYNC_STAGES(SD)) dut (
    .clk(clk), .nRst(nRst), .nCs_i(ncs), .sck_i(sck), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_TARGET_FRAME_ERR_EN
    , .frame_err(frame_err), .err_cnt(err_cnt)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: the DUT sees each pad SD cycles late; within a select window it
  // counts SCK rises (collecting MOSI) and falls (advancing through tx word).
  logic [2:0] ph[$];
  logic [2:0] s, h;
  int n, m_bits, m_falls, m_ecnt;
  bit armed, m_sel, m_pend, m_epend, m_rxv, m_err, exp_miso;
  logic [FB-1:0] m_rx, m_tx, m_rxd;
  always @(posedge clk) begin
    if (!nRst) begin
      ph.delete();
      repeat (SD + 1) ph.push_back(3'b100);
      n = 0; armed = 0; m_sel = 0; m_pend = 0; m_epend = 0; m_rxv = 0; m_err = 0;
      m_rxd = '0; m_rx = '0; m_tx = '0; m_ecnt = 0; m_bits = 0; m_falls = 0;
    end else begin
      n++;
      ph.push_back({ncs, sck, mosi});
      s = ph[ph.size()-1-SD];
      h = ph[ph.size()-2-SD];
      void'(ph.pop_front());
      m_rxv = m_pend;
      m_err = m_epend;
      if (m_pend) m_rxd = m_rx;
      if (m_epend && m_ecnt < 255) m_ecnt++;
      m_pend = 0;
      m_epend = 0;
      if (!m_sel) begin
        if (armed && h[2] && !s[2]) begin
          m_sel = 1; m_tx = tx_data; m_bits = 0; m_falls = 0;
        end
      end else if (!h[2] && s[2]) begin
        m_sel = 0;
        m_pend = (m_bits == FB);
        m_epend = (m_bits != FB);
      end else begin
        if (!h[1] && s[1]) begin
          m_rx = (m_rx << 1) | FB'(s[0]);
          if (m_bits <= FB) m_bits++;
        end
        if (h[1] && !s[1]) m_falls++;
      end
      if (n > SD && s[2]) armed = 1;
    end
    exp_miso = m_sel && m_falls < FB && m_tx[FB-1-m_falls];
    #2;
    chk("cycle", {miso_o, miso_oe_o, busy, rx_valid, rx_data}, {exp_miso, m_sel, m_sel, m_rxv, m_rxd});
`ifdef SPI_TARGET_FRAME_ERR_EN
    chk("cycle_err", {frame_err, err_cnt}, {m_err, 8'(m_ecnt)});
    if (frame_err) errs++;
`endif
    if (rx_valid) pulses.push_back(rx_data);
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic frame(input logic [FB-1:0] w, input logic [FB-1:0] t, input int len,
                       input int hp, input bit close, output logic [FB-1:0] mw);
    tx_data = t;
    ncs = 1'b0;
    mw = '0;
    for (int i = 0; i < len; i++) begin
      mosi = (i < FB) ? w[FB-1-i] : 1'($urandom);
      cyc(hp);
      if (i < FB) mw = {mw[FB-2:0], miso_o};
      sck = 1'b1;
      cyc(hp);
      sck = 1'b0;
    end
    cyc(hp);
    if (close) ncs = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [FB-1:0] mw, mw2, w, t;
    int lat, len, hp;
    bit seen;
    nRst = 1'b0; ncs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = '0;
    cyc(3);
    chk("reset_outputs", {miso_o, miso_oe_o, busy, rx_valid, rx_data}, 0);
    ncs = 1'b0;
    cyc(1);
    nRst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen |= busy | miso_oe_o;
    end
    chk("held_low_no_frame", 32'(seen), 0);
    ncs = 1'b1;
    cyc(8);
    frame(24'h123456, 24'hA5C3F0, 24, 4, 1, mw);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #3;
      if (rx_valid) lat = i;
    end
    chk("rx_valid_latency", 32'(lat), SD + 2);
    cyc(6);
    chk("good_rx_data", 32'(rx_data), 32'h123456);
    chk("good_miso_word", 32'(mw), 32'hA5C3F0);
    chk("good_pulses", 32'(pulses.size()), 1);
    frame(24'h654321, 24'h0, 23, 4, 1, mw);
    cyc(10);
    chk("short_rx_held", 32'(rx_data), 32'h123456);
    chk("short_pulses", 32'(pulses.size()), 1);
`ifdef SPI_TARGET_FRAME_ERR_EN
    chk("short_err_cnt", 32'(err_cnt), 1);
    chk("short_err_pulses", 32'(errs), 1);
`endif
    frame(24'h0ABCDE, 24'h111111, 25, 4, 1, mw);
    cyc(10);
    chk("overrun_rx_held", 32'(rx_data), 32'h123456);
    chk("overrun_pulses", 32'(pulses.size()), 1);
`ifdef SPI_TARGET_FRAME_ERR_EN
    chk("overrun_err_cnt", 32'(err_cnt), 2);
`endif
    frame(24'hFFFFFF, 24'h3C3C3C, 24, 5, 1, mw);
    cyc(10);
    chk("ones_rx_data", 32'(rx_data), 32'hFFFFFF);
    chk("ones_miso_word", 32'(mw), 32'h3C3C3C);
    frame(24'h000001, 24'h5A5A5A, 24, 4, 1, mw);
    cyc(1);
    frame(24'h800000, 24'hC0FFEE, 24, 4, 1, mw2);
    cyc(10);
    chk("b2b_pulses", 32'(pulses.size()), 4);
    chk("b2b_first", 32'(pulses[2]), 32'h000001);
    chk("b2b_second", 32'(pulses[3]), 32'h800000);
    chk("b2b_miso1", 32'(mw), 32'h5A5A5A);
    chk("b2b_miso2", 32'(mw2), 32'hC0FFEE);
    frame(24'hDEAD00, 24'h777777, 10, 4, 0, mw);
    nRst = 1'b0;
    cyc(1);
    chk("midreset_outputs", {miso_o, miso_oe_o, busy, rx_valid, rx_data}, 0);
    ncs = 1'b1;
    cyc(3);
    nRst = 1'b1;
    cyc(10);
    chk("midreset_pulses", 32'(pulses.size()), 4);
    frame(24'h0F0F0F, 24'h246813, 24, 4, 1, mw);
    cyc(10);
    chk("after_reset_rx", 32'(rx_data), 32'h0F0F0F);
    chk("after_reset_pulses", 32'(pulses.size()), 5);
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(0, 4);
      len = (len == 0) ? 23 : (len == 1) ? 25 : 24;
      hp = $urandom_range(4, 6);
      w = FB'($urandom);
      t = FB'($urandom);
      frame(w, t, len, hp, 1, mw);
      if (len >= FB) chk("rand_miso_word", 32'(mw), 32'(t));
      cyc($urandom_range(1, 8));
    end
    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
